// File: rtl/isqrt_seq.sv
// Sequential restoring integer square root: one root bit per clock, W/2 iterations, go/done handshake.
// Optional ISQRT_ROUND_EN: root rounds to nearest (saturating); rem always reports n - floor_root^2.
`timescale 1ns/1ps

module isqrt_seq #(
  parameter int W = 8
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           go,
  input  logic [W-1:0]   n,
  output logic           busy,
  output logic           done,
  output logic [W/2-1:0] root,
  output logic [W/2:0]   rem
);

  localparam int RW = W / 2;
  localparam int CW = $clog2(RW + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   x_q, x_d;
  logic [RW-1:0]  q_q, q_d;
  logic [RW+1:0]  r_q, r_d;
  logic [CW-1:0]  i_q, i_d;
  logic [RW-1:0]  root_q, root_d;
  logic [RW:0]    rem_q, rem_d;

  // One restoring step: trial-subtract {q,01} from the remainder with the next radicand pair appended.
  logic [1:0]     x_top;
  logic [RW+2:0]  trial_a, trial_b, trial_diff;
  logic           trial_ge;
  logic [RW+1:0]  r_iter;
  logic [RW:0]    q_shift;
  logic [RW-1:0]  q_iter;
  logic [RW-1:0]  root_fin;
  logic           last_iter;

  always_comb begin
    x_top      = x_q[W-1:W-2];
    trial_a    = {r_q[RW:0], x_top};
    trial_b    = {1'b0, q_q, 2'b01};
    trial_diff = trial_a - trial_b;
    trial_ge   = (trial_a >= trial_b);
    r_iter     = trial_ge ? trial_diff[RW+1:0] : trial_a[RW+1:0];
    q_shift    = {q_q, trial_ge};
    q_iter     = q_shift[RW-1:0];
    last_iter  = (i_q == CW'(RW - 1));
`ifdef ISQRT_ROUND_EN
    // r > q means n sits past the midpoint (q+0.5)^2; saturate when q is already all ones.
    if ((r_iter > {2'b00, q_iter}) && (q_iter != {RW{1'b1}}))
      root_fin = q_iter + RW'(1);
    else
      root_fin = q_iter;
`else
    root_fin = q_iter;
`endif
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    q_d     = q_q;
    r_d     = r_q;
    i_d     = i_q;
    root_d  = root_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE, DONE: begin
        if (go) begin
          state_d = CALC;
          x_d     = n;
          q_d     = '0;
          r_d     = '0;
          i_d     = '0;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      CALC: begin
        x_d = x_q << 2;
        q_d = q_iter;
        r_d = r_iter;
        i_d = i_q + CW'(1);
        if (last_iter) begin
          state_d = DONE;
          root_d  = root_fin;
          rem_d   = r_iter[RW:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
      i_q     <= '0;
      root_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      q_q     <= q_d;
      r_q     <= r_d;
      i_q     <= i_d;
      root_q  <= root_d;
      rem_q   <= rem_d;
    end
  end

  assign busy = (state_q == CALC);
  assign done = (state_q == DONE);
  assign root = root_q;
  assign rem  = rem_q;

endmodule
